alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
Shares the single 7-bit NAND/ROL ALU between two independent requesters (channel 0, channel 1) using valid/ready handshakes and round-robin arbitration. It latches the winning operands, drives the ALU operand/opcode inputs, and waits a configurable ALU latency. It then captures the ALU result and returns it to the granted channel as a one-cycle response. It sits between the stimulus/controller layer and the ALU, replacing direct hard-wired driving of the ALU inputs.

Parameters:
ALU_LAT, 0, cycles from ALU inputs stable to alu_r valid (legal 0..3; 0 = combinational ALU)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  channel 0 request valid
req0_ready  out  1  channel 0 accepted this cycle
req0_a  in  7  channel 0 operand A
req0_b  in  7  channel 0 operand B
req0_op  in  2  channel 0 opcode (00 NAND, 01 ROL, 10/11 illegal)
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as channel 0, for channel 1
alu_a  out  7  ALU operand A (registered)
alu_b  out  7  ALU operand B (registered)
alu_op  out  2  ALU opcode (registered)
alu_r  in  7  ALU result
rsp0_valid  out  1  one-cycle pulse: response for channel 0
rsp1_valid  out  1  one-cycle pulse: response for channel 1
rsp_r  out  7  captured result; held until next capture
rsp_err  out  1  response is for an illegal opcode; qualified by rspX_valid
busy  out  1  high in any state other than IDLE
op_cnt  out  8  count of responses issued (including errors); wraps 255->0

Behaviour:
- Reset (async, any state): state=IDLE; rr pointer favours channel 0. All outputs 0: alu_a, alu_b, alu_op, rsp_r, rsp_err, rspX_valid, op_cnt, busy, reqX_ready. An in-flight op is dropped; no response is issued for it.
- States: IDLE, EXEC, RESP.
- IDLE: reqX_ready is combinational and asserted only here, for exactly one granted channel.
  - Single valid: that channel is granted.
  - Both valid: the channel not granted last is granted; after reset channel 0 wins.
- Transfer occurs on reqX_valid && reqX_ready. On that edge, the rr pointer is updated to the granted channel and the granted id is stored.
  - Legal op: load alu_a/alu_b/alu_op from the request, load the latency counter with ALU_LAT, go to EXEC.
  - Illegal op (10/11): alu_* stay 0, EXEC is skipped, go to RESP with err=1 and rsp_r loaded with 0.
- EXEC: alu_* are held stable. When counter==0, alu_r is captured into rsp_r on that edge and the state goes to RESP; otherwise the counter decrements.
- RESP (exactly one cycle):
  - rspX_valid=1 for the stored channel only; rsp_err is valid.
  - On the exit edge: alu_* are cleared to 0, op_cnt increments, state returns to IDLE.
- Timing: accept edge at cycle T; EXEC spans cycles T+1..T+1+ALU_LAT; rspX_valid is high in cycle T+2+ALU_LAT. Illegal op: rsp in cycle T+1.
- Throughput: one op per ALU_LAT+3 cycles. reqX_ready=0 in EXEC and RESP.
- Requesters must hold valid and data stable until ready. A valid dropped before ready is simply never granted, with no side effects.
- alu_* are 0 whenever the state is not EXEC (drive ALU with zeros when idle).
- rsp_r is not cleared after RESP; it is overwritten only by the next capture.
- op_cnt wraps 255->0 without a flag.
- Valid asserted during reset: no grant until the first clock edge after rst deasserts.

Test Plan:
Bench ALU model: NAND r=~(a&b); ROL r = a rotated left by b[2:0] within 7 bits. Run each scenario with ALU_LAT=0 and ALU_LAT=2.
1. req0 only, a=1010101 b=0101010 op=00 -> req0_ready 1 cycle; alu_a/b/op driven for ALU_LAT+1 cycles; rsp0_valid in cycle T+2+ALU_LAT with rsp_r=1111111, rsp_err=0; rsp1_valid stays 0; op_cnt=1.
2. req1 only, a=1110000 b=0000011 op=01 -> rsp1_valid with rsp_r=0000111.
3. Both channels valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; responses route to the matching rspX_valid; no ready during EXEC/RESP.
4. req0 op=11 -> rsp0_valid in cycle T+1 with rsp_err=1, rsp_r=0; alu_* never leave 0.
5. rst pulsed mid-EXEC (ALU_LAT=2) -> all outputs 0 immediately; no rsp for the dropped op; next request is granted to channel 0 even if channel 0 was last.
6. 256 back-to-back ops -> op_cnt wraps to 0; a=0000000 b=0000001 NAND returns 1111111.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 7-bit NAND/ROL ALU between two valid/ready requesters.
// Operands are registered toward the ALU; the result returns as a one-cycle response pulse.
module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [6:0] req0_a,
    input  logic [6:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [6:0] req1_a,
    input  logic [6:0] req1_b,
    input  logic [1:0] req1_op,
    output logic [6:0] alu_a,
    output logic [6:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [6:0] alu_r,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [6:0] rsp_r,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] op_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       last_gnt;
    logic       gnt_id;
    logic       err_q;
    logic       gnt;
    logic       take;
    logic [6:0] sel_a;
    logic [6:0] sel_b;
    logic [1:0] sel_op;

    // Contention goes to the channel that did not win last; rst blocks any grant.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = ~last_gnt;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
        take   = !rst && (state == IDLE) && (req0_valid || req1_valid);
        sel_a  = gnt ? req1_a  : req0_a;
        sel_b  = gnt ? req1_b  : req0_b;
        sel_op = gnt ? req1_op : req0_op;
    end

    assign req0_ready = take && !gnt;
    assign req1_ready = take && gnt;
    assign busy       = (state != IDLE);
    assign rsp0_valid = (state == RESP) && !gnt_id;
    assign rsp1_valid = (state == RESP) && gnt_id;
    assign rsp_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= 2'd0;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            err_q    <= 1'b0;
            alu_a    <= 7'd0;
            alu_b    <= 7'd0;
            alu_op   <= 2'd0;
            rsp_r    <= 7'd0;
            op_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        last_gnt <= gnt;
                        gnt_id   <= gnt;
                        // Illegal opcodes never reach the ALU and answer with an error next cycle.
                        if (sel_op[1]) begin
                            err_q <= 1'b1;
                            rsp_r <= 7'd0;
                            state <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_op  <= sel_op;
                            lat_cnt <= 2'(ALU_LAT);
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_r  <= alu_r;
                        alu_a  <= 7'd0;
                        alu_b  <= 7'd0;
                        alu_op <= 2'd0;
                        state  <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    alu_a  <= 7'd0;
                    alu_b  <= 7'd0;
                    alu_op <= 2'd0;
                    err_q  <= 1'b0;
                    op_cnt <= op_cnt + 8'd1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
